// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader
// Read-side controller for an HD44780-style character LCD bus. It requests the
// shared LCD pins from the display writer, then performs one status read
// (RS=0, busy flag + address counter) or one data read (RS=1). Status reads
// can optionally poll until the busy flag clears, or until MAX_POLLS reads
// have been made.
//
// Ports:
//   iCLK_50MHZ   system clock
//   iRST_N       asynchronous active-low reset
//   iREQ         start request, only looked at while idle
//   iRS          0 = status read, 1 = data read (captured with iREQ)
//   iPOLL        repeat status reads until BF=0 (captured with iREQ)
//   iBUS_GNT     writer has released the LCD pins
//   LCD_DATA_IN  LCD data bus as seen by the FPGA
//   oBUS_REQ     request for LCD pin ownership
//   oBUSY        high whenever a transaction is in progress
//   oACK         one-cycle completion pulse
//   oRDATA       last byte sampled from the LCD
//   oTIMEOUT     poll limit reached with BF still set (valid with oACK)
//   oABORT       grant was lost mid-cycle (valid with oACK)
//   LCD_RW       1 = read
//   LCD_E        LCD enable strobe
//   LCD_RS       register select
`timescale 1ns/1ps

module lcd_bus_reader #(
  parameter int T_AS      = 3,
  parameter int T_EH      = 16,
  parameter int T_EL      = 16,
  parameter int MAX_POLLS = 1000
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic       iPOLL,
  input  logic       iBUS_GNT,
  input  logic [7:0] LCD_DATA_IN,
  output logic       oBUS_REQ,
  output logic       oBUSY,
  output logic       oACK,
  output logic [7:0] oRDATA,
  output logic       oTIMEOUT,
  output logic       oABORT,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       LCD_RS
);

  localparam int T_MAX = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                       : ((T_EH > T_EL) ? T_EH : T_EL);
  localparam int CW = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;
  localparam int PW = ($clog2(MAX_POLLS) > 0) ? $clog2(MAX_POLLS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GNT_WAIT,
    SETUP,
    E_HIGH,
    E_HOLD,
    DONE
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [PW-1:0] poll_cnt;
  logic          rs_q;
  logic          poll_mode_q;
  logic [7:0]    rdata_q;
  logic          timeout_q;
  logic          abort_q;

  logic          start;
  logic          sample;
  logic          poll_next;
  logic          set_timeout;
  logic          set_abort;
  logic          bf_retry;

  // Another status read is due when polling, the byte just read still shows
  // BF=1, and the read budget is not yet exhausted.
  assign bf_retry = poll_mode_q && rdata_q[7] &&
                    ((int'(poll_cnt) + 1) < MAX_POLLS);

  // State and phase timer. The single down-counter is reloaded on every phase
  // entry and the phase ends when it reaches zero.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic and pin decoding. Losing the grant in any bus phase
  // wins over phase timing, so a grant drop on the last E_HIGH cycle ends the
  // cycle without sampling. RS and RW are only driven during the three bus
  // phases, so they can only change while E is low.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    start       = 1'b0;
    sample      = 1'b0;
    poll_next   = 1'b0;
    set_timeout = 1'b0;
    set_abort   = 1'b0;
    oBUS_REQ    = 1'b0;
    oBUSY       = 1'b1;
    oACK        = 1'b0;
    LCD_RW      = 1'b0;
    LCD_E       = 1'b0;
    LCD_RS      = 1'b0;
    case (state)
      IDLE: begin
        oBUSY = 1'b0;
        if (iREQ) begin
          start   = 1'b1;
          state_d = GNT_WAIT;
        end
      end
      GNT_WAIT: begin
        oBUS_REQ = 1'b1;
        if (iBUS_GNT) begin
          state_d = SETUP;
          cnt_d   = CW'(T_AS - 1);
        end
      end
      SETUP: begin
        oBUS_REQ = 1'b1;
        LCD_RW   = 1'b1;
        LCD_RS   = rs_q;
        if (!iBUS_GNT) begin
          state_d   = DONE;
          set_abort = 1'b1;
        end else if (cnt == '0) begin
          state_d = E_HIGH;
          cnt_d   = CW'(T_EH - 1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      E_HIGH: begin
        oBUS_REQ = 1'b1;
        LCD_RW   = 1'b1;
        LCD_RS   = rs_q;
        LCD_E    = 1'b1;
        if (!iBUS_GNT) begin
          state_d   = DONE;
          set_abort = 1'b1;
        end else if (cnt == '0) begin
          sample  = 1'b1;
          state_d = E_HOLD;
          cnt_d   = CW'(T_EL - 1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      E_HOLD: begin
        oBUS_REQ = 1'b1;
        LCD_RW   = 1'b1;
        LCD_RS   = rs_q;
        if (!iBUS_GNT) begin
          state_d   = DONE;
          set_abort = 1'b1;
        end else if (cnt == '0) begin
          if (bf_retry) begin
            poll_next = 1'b1;
            state_d   = SETUP;
            cnt_d     = CW'(T_AS - 1);
          end else begin
            state_d     = DONE;
            set_timeout = poll_mode_q && rdata_q[7];
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      DONE: begin
        oACK    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction context and results. Polling is only meaningful for status
  // reads, so a data read with iPOLL set is folded into a single read here.
  // The timeout/abort flags are loaded on the edge entering DONE and cleared
  // on the next edge, so they are high exactly in the DONE cycle.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      rs_q        <= 1'b0;
      poll_mode_q <= 1'b0;
      poll_cnt    <= '0;
      rdata_q     <= 8'h00;
      timeout_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      if (start) begin
        rs_q        <= iRS;
        poll_mode_q <= iPOLL & ~iRS;
        poll_cnt    <= '0;
      end else if (poll_next) begin
        poll_cnt <= poll_cnt + PW'(1);
      end
      if (sample) begin
        rdata_q <= LCD_DATA_IN;
      end
      timeout_q <= set_timeout;
      abort_q   <= set_abort;
    end
  end

  assign oRDATA   = rdata_q;
  assign oTIMEOUT = timeout_q;
  assign oABORT   = abort_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader
// Drives two lcd_bus_reader instances (default MAX_POLLS and MAX_POLLS=4).
// Each transaction is first expanded into a cycle-by-cycle table of inputs
// and expected outputs from the read-cycle timing rules, then replayed while
// the outputs of the selected instance are compared every cycle.
`timescale 1ns/1ps

module tb_lcd_bus_reader;

  localparam int T_AS = 3;
  localparam int T_EH = 16;
  localparam int T_EL = 16;
  localparam int P    = T_AS + T_EH + T_EL;

  typedef struct {
    logic        req;
    logic        rs;
    logic        poll;
    logic        gnt;
    logic [7:0]  data;
    logic [15:0] exp;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a;
  logic       req_b;
  logic       rs_in;
  logic       poll_in;
  logic       gnt;
  logic [7:0] data_in;
  logic       sel;

  logic       a_bus_req, a_busy, a_ack, a_timeout, a_abort, a_rw, a_e, a_rs;
  logic [7:0] a_rdata;
  logic       b_bus_req, b_busy, b_ack, b_timeout, b_abort, b_rw, b_e, b_rs;
  logic [7:0] b_rdata;

  logic [15:0] a_vec;
  logic [15:0] b_vec;
  logic [15:0] act_vec;

  step_t      trace[$];
  logic [7:0] m_bytes[$];
  logic [7:0] m_rdata[2];
  int         m_ack_offset;
  int         m_pulses;

  int         tests = 0;
  int         fails = 0;
  int         meas_pulses;
  int         cur_w;
  int         last_w;
  logic       e_prev;
  logic       last_tmo;
  logic       last_abt;

  always #10 clk = ~clk;

  lcd_bus_reader u_dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .iREQ       (req_a),
    .iRS        (rs_in),
    .iPOLL      (poll_in),
    .iBUS_GNT   (gnt),
    .LCD_DATA_IN(data_in),
    .oBUS_REQ   (a_bus_req),
    .oBUSY      (a_busy),
    .oACK       (a_ack),
    .oRDATA     (a_rdata),
    .oTIMEOUT   (a_timeout),
    .oABORT     (a_abort),
    .LCD_RW     (a_rw),
    .LCD_E      (a_e),
    .LCD_RS     (a_rs)
  );

  lcd_bus_reader #(.MAX_POLLS(4)) u_dut4 (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .iREQ       (req_b),
    .iRS        (rs_in),
    .iPOLL      (poll_in),
    .iBUS_GNT   (gnt),
    .LCD_DATA_IN(data_in),
    .oBUS_REQ   (b_bus_req),
    .oBUSY      (b_busy),
    .oACK       (b_ack),
    .oRDATA     (b_rdata),
    .oTIMEOUT   (b_timeout),
    .oABORT     (b_abort),
    .LCD_RW     (b_rw),
    .LCD_E      (b_e),
    .LCD_RS     (b_rs)
  );

  assign a_vec   = {a_bus_req, a_busy, a_ack, a_timeout, a_abort, a_rw, a_e, a_rs, a_rdata};
  assign b_vec   = {b_bus_req, b_busy, b_ack, b_timeout, b_abort, b_rw, b_e, b_rs, b_rdata};
  assign act_vec = sel ? b_vec : a_vec;

  function automatic logic [15:0] pack_exp(input logic br, input logic bz, input logic ak,
                                           input logic tm, input logic ab, input logic rw,
                                           input logic e, input logic rs, input logic [7:0] rd);
    return {br, bz, ak, tm, ab, rw, e, rs, rd};
  endfunction

  // Inputs for a cycle where only req must be held low; the rest is noise.
  function automatic step_t noise_step(input bit noisy);
    step_t s;
    s.req  = 1'b0;
    s.rs   = noisy ? 1'($urandom) : 1'b0;
    s.poll = noisy ? 1'($urandom) : 1'b0;
    s.gnt  = noisy ? 1'($urandom) : 1'b0;
    s.data = noisy ? 8'($urandom) : 8'h00;
    s.exp  = 16'h0000;
    return s;
  endfunction

  task automatic push_idle(input int who, input bit noisy);
    step_t s;
    s = noise_step(noisy);
    s.exp = pack_exp(0, 0, 0, 0, 0, 0, 0, 0, m_rdata[who]);
    trace.push_back(s);
  endtask

  // Expand one request into per-cycle inputs and expected outputs. drop_at is
  // the bus-phase cycle (counted from the first setup cycle) in which the
  // grant is withdrawn, or -1 for none.
  task automatic build_trace(input int who, input logic rs, input logic poll,
                             input int gnt_delay, input int drop_at, input bit noisy,
                             input int idle_n, input int max_polls);
    step_t      s;
    logic [7:0] d;
    logic       poll_mode;
    int         active;
    int         req_idx;
    bit         aborted;
    bit         tmo;
    trace.delete();
    m_pulses = 0;
    for (int i = 0; i < idle_n; i++) push_idle(who, noisy);
    s = noise_step(noisy);
    s.req  = 1'b1;
    s.rs   = rs;
    s.poll = poll;
    s.exp  = pack_exp(0, 0, 0, 0, 0, 0, 0, 0, m_rdata[who]);
    req_idx = trace.size();
    trace.push_back(s);
    for (int i = 0; i <= gnt_delay; i++) begin
      s = noise_step(noisy);
      s.req = noisy ? 1'($urandom) : 1'b0;
      s.gnt = (i == gnt_delay);
      s.exp = pack_exp(1, 1, 0, 0, 0, 0, 0, 0, m_rdata[who]);
      trace.push_back(s);
    end
    poll_mode = poll & ~rs;
    active    = 0;
    aborted   = 0;
    tmo       = 0;
    for (int r = 0; r < max_polls; r++) begin
      d = (r < m_bytes.size()) ? m_bytes[r] : m_bytes[m_bytes.size()-1];
      for (int o = 0; o < P; o++) begin
        s = noise_step(noisy);
        s.req = noisy ? 1'($urandom) : 1'b0;
        s.gnt = (active != drop_at);
        if (!noisy || o == T_AS + T_EH - 1) s.data = d;
        s.exp = pack_exp(1, 1, 0, 0, 0, 1, (o >= T_AS && o < T_AS + T_EH), rs, m_rdata[who]);
        trace.push_back(s);
        if (o == T_AS) m_pulses++;
        if (!s.gnt) begin
          aborted = 1;
          break;
        end
        if (o == T_AS + T_EH - 1) m_rdata[who] = d;
        active++;
      end
      if (aborted) break;
      if (!(poll_mode && m_rdata[who][7])) break;
      if (r + 1 >= max_polls) begin
        tmo = 1;
        break;
      end
    end
    s = noise_step(noisy);
    s.req = noisy ? 1'($urandom) : 1'b0;
    s.exp = pack_exp(0, 1, 1, tmo, aborted, 0, 0, 0, m_rdata[who]);
    trace.push_back(s);
    m_ack_offset = trace.size() - 1 - req_idx;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic meas_clear();
    meas_pulses = 0;
    cur_w       = 0;
    last_w      = 0;
    e_prev      = 1'b0;
    last_tmo    = 1'b0;
    last_abt    = 1'b0;
  endtask

  // Replay the table: inputs just after the rising edge, compare on the
  // falling edge, and keep E-pulse statistics of the selected instance.
  task automatic applyStimulus(input string name, input int who, input int limit);
    step_t s;
    logic  e_now;
    for (int i = 0; i < trace.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      @(posedge clk);
      #1;
      s       = trace[i];
      sel     = who[0];
      req_a   = (who == 0) ? s.req : 1'b0;
      req_b   = (who == 1) ? s.req : 1'b0;
      rs_in   = s.rs;
      poll_in = s.poll;
      gnt     = s.gnt;
      data_in = s.data;
      @(negedge clk);
      checkOutput(name, 32'(act_vec), 32'(s.exp));
      e_now = act_vec[9];
      if (e_now && !e_prev) meas_pulses++;
      if (e_now) cur_w++;
      else if (cur_w != 0) begin
        last_w = cur_w;
        cur_w  = 0;
      end
      e_prev = e_now;
      if (act_vec[13]) begin
        last_tmo = act_vec[12];
        last_abt = act_vec[11];
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    int         who;
    int         n;
    int         drop;

    rst_n   = 1'b0;
    sel     = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    rs_in   = 1'b0;
    poll_in = 1'b0;
    gnt     = 1'b0;
    data_in = 8'h00;
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
    meas_clear();
    #5;
    checkOutput("reset outputs A", 32'(a_vec), 32'd0);
    checkOutput("reset outputs B", 32'(b_vec), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    m_bytes.delete(); m_bytes.push_back(8'h25);
    build_trace(0, 0, 0, 0, -1, 0, 2, 1000);
    checkOutput("model ack latency", 32'(m_ack_offset), 32'd37);
    meas_clear();
    applyStimulus("status read", 0, -1);
    checkOutput("status read pulses", 32'(meas_pulses), 32'd1);
    checkOutput("status read E width", 32'(last_w), 32'd16);
    checkOutput("status read rdata", 32'(a_rdata), 32'h25);
    checkOutput("status read timeout", 32'(last_tmo), 32'd0);

    m_bytes.delete(); m_bytes.push_back(8'h41);
    build_trace(0, 1, 0, 0, -1, 0, 1, 1000);
    meas_clear();
    applyStimulus("data read", 0, -1);
    checkOutput("data read rdata", 32'(a_rdata), 32'h41);
    checkOutput("data read pulses", 32'(meas_pulses), 32'd1);

    m_bytes.delete(); m_bytes.push_back(8'hC1);
    build_trace(0, 1, 1, 0, -1, 0, 1, 1000);
    meas_clear();
    applyStimulus("data read with poll", 0, -1);
    checkOutput("data poll pulses", 32'(meas_pulses), 32'd1);
    checkOutput("data poll rdata", 32'(a_rdata), 32'hC1);

    m_bytes.delete();
    m_bytes.push_back(8'h80); m_bytes.push_back(8'h80);
    m_bytes.push_back(8'h80); m_bytes.push_back(8'h07);
    build_trace(0, 0, 1, 0, -1, 0, 1, 1000);
    checkOutput("model poll latency", 32'(m_ack_offset), 32'd142);
    checkOutput("model poll pulses", 32'(m_pulses), 32'd4);
    meas_clear();
    applyStimulus("poll", 0, -1);
    checkOutput("poll pulses", 32'(meas_pulses), 32'd4);
    checkOutput("poll rdata", 32'(a_rdata), 32'h07);
    checkOutput("poll timeout", 32'(last_tmo), 32'd0);

    m_bytes.delete(); m_bytes.push_back(8'hFF);
    build_trace(1, 0, 1, 0, -1, 0, 1, 4);
    meas_clear();
    applyStimulus("poll timeout", 1, -1);
    checkOutput("timeout pulses", 32'(meas_pulses), 32'd4);
    checkOutput("timeout flag", 32'(last_tmo), 32'd1);
    checkOutput("timeout rdata", 32'(b_rdata), 32'hFF);

    m_bytes.delete(); m_bytes.push_back(8'h3C);
    build_trace(0, 0, 0, 10, T_AS + 5, 0, 1, 1000);
    meas_clear();
    applyStimulus("grant loss", 0, -1);
    checkOutput("grant loss pulses", 32'(meas_pulses), 32'd1);
    checkOutput("grant loss E width", 32'(last_w), 32'd6);
    checkOutput("grant loss abort", 32'(last_abt), 32'd1);
    checkOutput("grant loss rdata kept", 32'(a_rdata), 32'h07);

    m_bytes.delete(); m_bytes.push_back(8'h5A);
    build_trace(0, 0, 0, 0, -1, 0, 2, 1000);
    applyStimulus("pre reset", 0, 12);
    checkOutput("mid E_HIGH before reset", 32'(a_e), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async reset A", 32'(a_vec), 32'd0);
    checkOutput("async reset B", 32'(b_vec), 32'd0);
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    trace.delete();
    for (int i = 0; i < 4; i++) push_idle(0, 0);
    applyStimulus("idle after reset", 0, -1);

    for (int t = 0; t < 40; t++) begin
      who = $urandom_range(0, 1);
      n   = $urandom_range(1, 5);
      m_bytes.delete();
      for (int i = 0; i < n; i++) begin
        b    = 8'($urandom);
        b[7] = 1'($urandom_range(0, 1));
        if (who == 0 && i == n - 1) b[7] = 1'b0;
        m_bytes.push_back(b);
      end
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n * P)) : -1;
      build_trace(who, 1'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 4),
                  drop, 1, $urandom_range(0, 3), (who == 1) ? 4 : 1000);
      applyStimulus("random", who, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
